sdrio_serdes_xn: RTL and testbench

- Parametrised N-lane, RATIO:1 SDR serializer/deserializer for the PHY data path. Runs entirely on the fast edge clock.
- Per lane it serializes a parallel data word and a per-bit output-enable word onto txd/ten, and deserializes rxd into parallel words.
- Provides per-lane bitslip word alignment, which the fixed 4:1 output-only lane did not have.
- Sits between the PHY datapath and the IOC/GPIO primitive wrappers.

---
 rtl/sdrio_serdes_xn.sv | 117 +++++++++++
 tb/tb_sdrio_serdes_xn.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/sdrio_serdes_xn.sv
// sdrio_serdes_xn
// N-lane RATIO:1 SDR serializer/deserializer running on the fast edge clock.
// Each lane serializes a parallel data word (d) and a per-bit output-enable
// word (t) onto txd/ten. It also deserializes rxd into parallel words (q),
// with per-lane bitslip word alignment.
//
// Ports:
//   geclk    fast edge clock, all logic on its rising edge
//   rst      synchronous reset, active high
//   cken     clock enable, 0 freezes all state
//   d, t     TX data / output-enable words, lane i = [i*RATIO +: RATIO], bit 0 first
//   txd, ten serial data / output enable to the IOC
//   rxd      serial data from the IOC
//   q        RX parallel words, bit 0 is the earliest bit
//   q_valid  one-cycle pulse after q updates
//   load     high in the cycle before an update edge
//   bitslip  per-lane slip request pulse
//   slip_off per-lane word offset
module sdrio_serdes_xn #(
  parameter int LANES        = 8,
  parameter int RATIO        = 4,
  parameter int UPDATE_PHASE = 1,
  parameter int OFFW         = $clog2(RATIO)
) (
  input  logic                    geclk,
  input  logic                    rst,
  input  logic                    cken,
  input  logic [LANES*RATIO-1:0]  d,
  input  logic [LANES*RATIO-1:0]  t,
  output logic [LANES-1:0]        txd,
  output logic [LANES-1:0]        ten,
  input  logic [LANES-1:0]        rxd,
  output logic [LANES*RATIO-1:0]  q,
  output logic                    q_valid,
  output logic                    load,
  input  logic [LANES-1:0]        bitslip,
  output logic [LANES*OFFW-1:0]   slip_off
);

  localparam int CW = $clog2(RATIO);
  localparam int HW = 2*RATIO-1;
  localparam logic [CW-1:0]   UPD_CNT  = CW'(UPDATE_PHASE);
  localparam logic [CW-1:0]   LAST_CNT = CW'(RATIO-1);
  localparam logic [OFFW-1:0] LAST_OFF = OFFW'(RATIO-1);

  logic [CW-1:0] cnt;
  logic          upd;

  assign load = (cnt == UPD_CNT);
  assign upd  = cken & load;

  always_ff @(posedge geclk) begin
    if (rst) begin
      cnt     <= '0;
      q_valid <= 1'b0;
    end else begin
      q_valid <= upd;
      if (cken)
        cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [RATIO-1:0] dsr, tsr, qr, q_nxt;
    logic [HW-1:0]    hist, hist_nxt;
    logic [OFFW-1:0]  off;
    logic             pend;

    // hist_nxt[m] is the rxd sampled m enabled edges before the current one.
    // The current edge's sample is included, so a capture sees it.
    assign hist_nxt = {hist[HW-2:0], rxd[i]};

    always_comb begin
      q_nxt = '0;
      for (int b = 0; b < RATIO; b++) begin
        int idx;
        idx      = RATIO - 1 + int'(off) - b;
        q_nxt[b] = hist_nxt[idx];
      end
    end

    always_ff @(posedge geclk) begin
      if (rst) begin
        dsr  <= '0;
        tsr  <= '0;
        hist <= '0;
        qr   <= '0;
        off  <= '0;
        pend <= 1'b0;
      end else if (cken) begin
        hist <= hist_nxt;
        if (upd) begin
          dsr <= d[i*RATIO +: RATIO];
          tsr <= t[i*RATIO +: RATIO];
          qr  <= q_nxt;
        end else begin
          dsr <= {1'b0, dsr[RATIO-1:1]};
          tsr <= {1'b0, tsr[RATIO-1:1]};
        end
        // The capture on the applying edge still uses the old offset.
        // A pulse that arrives while a slip is pending is dropped.
        if (upd && pend) begin
          off  <= (off == LAST_OFF) ? '0 : off + 1'b1;
          pend <= 1'b0;
        end else if (bitslip[i] && !pend) begin
          pend <= 1'b1;
        end
      end
    end

    assign txd[i]                  = dsr[0];
    assign ten[i]                  = tsr[0];
    assign q[i*RATIO +: RATIO]     = qr;
    assign slip_off[i*OFFW +: OFFW] = off;
  end

endmodule

// File: tb/tb_sdrio_serdes_xn.sv
// Directed bench for sdrio_serdes_xn (LANES=2, RATIO=4, UPDATE_PHASE=1).
// txd is looped back to rxd throughout.
module tb_sdrio_serdes_xn;

  logic       geclk = 1'b0;
  logic       rst, cken;
  logic [7:0] d, t, q;
  logic [1:0] txd, ten, rxd, bitslip;
  logic [3:0] slip_off;
  logic       q_valid, load;

  int checks = 0;
  int errors = 0;

  assign rxd = txd;

  sdrio_serdes_xn #(.LANES(2), .RATIO(4), .UPDATE_PHASE(1)) dut (
    .geclk(geclk), .rst(rst), .cken(cken), .d(d), .t(t),
    .txd(txd), .ten(ten), .rxd(rxd), .q(q), .q_valid(q_valid),
    .load(load), .bitslip(bitslip), .slip_off(slip_off)
  );

  always #5 geclk = ~geclk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge geclk);
    #1;
  endtask

  // One word period.
  // Precondition: load=1.
  // qe*/oe are the q and lane0 slip_off expected after this word's update edge.
  // smask[j] pulses bitslip on lane0 during edge j.
  // frz_j is the edge after which cken drops for 3 cycles (-1 = none).
  task automatic do_word(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] t0,
                         input logic [3:0] smask, input logic [3:0] qe0, input logic [3:0] qe1,
                         input logic [1:0] oe, input int frz_j);
    d = {d1, d0};
    t = {4'hF, t0};
    check("load_pre", load, 1);
    for (int j = 0; j < 4; j++) begin
      bitslip = {1'b0, smask[j]};
      tick();
      bitslip = 2'b00;
      check("txd0", txd[0], d0[j]);
      check("ten0", ten[0], t0[j]);
      check("txd1", txd[1], d1[j]);
      if (j == 0) begin
        check("q_valid_upd", q_valid, 1);
        check("q_lane0", q[3:0], qe0);
        check("q_lane1", q[7:4], qe1);
        check("slip_off0", slip_off[1:0], oe);
        check("slip_off1", slip_off[3:2], 0);
      end else begin
        check("q_valid_idle", q_valid, 0);
      end
      if (j == frz_j) begin
        cken    = 1'b0;
        bitslip = 2'b11;
        repeat (3) begin
          tick();
          check("frz_txd0", txd[0], d0[j]);
          check("frz_ten0", ten[0], t0[j]);
          check("frz_q_valid", q_valid, 0);
          check("frz_load", load, (j == 3));
          check("frz_q0", q[3:0], qe0);
        end
        cken    = 1'b1;
        bitslip = 2'b00;
      end
    end
  endtask

  initial begin
    rst = 1'b1; cken = 1'b1; d = '0; t = '0; bitslip = '0;
    repeat (3) tick();
    check("rst_txd", txd, 0);
    check("rst_ten", ten, 0);
    check("rst_q", q, 0);
    check("rst_q_valid", q_valid, 0);
    check("rst_slip_off", slip_off, 0);
    rst = 1'b0;
    tick();
    check("rel_load", load, 1);
    check("rel_q_valid", q_valid, 0);

    // TX word, then loopback sequence: q returns the previous word.
    do_word(4'b1011, 4'hF, 4'b0111, 4'b0000, 4'h0, 4'h0, 2'd0, -1);
    do_word(4'h5, 4'hF, 4'hF, 4'b0000, 4'hB, 4'hF, 2'd0, -1);
    do_word(4'hA, 4'hF, 4'hF, 4'b0000, 4'h5, 4'hF, 2'd0, -1);
    do_word(4'hC, 4'hF, 4'hF, 4'b0000, 4'hA, 4'hF, 2'd0, -1);
    do_word(4'h3, 4'hF, 4'hF, 4'b0000, 4'hC, 4'hF, 2'd0, -1);
    do_word(4'h1, 4'hF, 4'hF, 4'b0000, 4'h3, 4'hF, 2'd0, -1);

    // Bitslip walk with a constant 0001 word: q = 0001 rotated left by off.
    do_word(4'h1, 4'hF, 4'hF, 4'b0010, 4'h1, 4'hF, 2'd0, -1);
    do_word(4'h1, 4'hF, 4'hF, 4'b0000, 4'h1, 4'hF, 2'd1, -1);
    do_word(4'h1, 4'hF, 4'hF, 4'b0010, 4'h2, 4'hF, 2'd1, -1);
    do_word(4'h1, 4'hF, 4'hF, 4'b0010, 4'h2, 4'hF, 2'd2, -1);
    do_word(4'h1, 4'hF, 4'hF, 4'b0010, 4'h4, 4'hF, 2'd3, -1);
    do_word(4'h1, 4'hF, 4'hF, 4'b0000, 4'h8, 4'hF, 2'd0, -1);

    // Pulse coincident with an update edge applies at the next one.
    do_word(4'h1, 4'hF, 4'hF, 4'b0001, 4'h1, 4'hF, 2'd0, -1);
    do_word(4'h1, 4'hF, 4'hF, 4'b0000, 4'h1, 4'hF, 2'd1, -1);

    // Two pulses in one word period advance by one only.
    do_word(4'h1, 4'hF, 4'hF, 4'b0110, 4'h2, 4'hF, 2'd1, -1);
    do_word(4'h1, 4'hF, 4'hF, 4'b0000, 4'h2, 4'hF, 2'd2, -1);
    do_word(4'h1, 4'hF, 4'hF, 4'b0000, 4'h4, 4'hF, 2'd2, -1);

    // cken low for 3 cycles mid-word, with bitslip asserted meanwhile (ignored).
    do_word(4'h6, 4'hF, 4'hF, 4'b0000, 4'h4, 4'hF, 2'd2, 1);
    do_word(4'h1, 4'hF, 4'hF, 4'b0000, 4'h8, 4'hF, 2'd2, -1);
    do_word(4'h1, 4'hF, 4'hF, 4'b0000, 4'h5, 4'hF, 2'd2, -1);

    // Reset mid-traffic with a nonzero slip offset.
    d = {4'hF, 4'h7};
    rst = 1'b1;
    repeat (3) tick();
    check("mrst_txd", txd, 0);
    check("mrst_ten", ten, 0);
    check("mrst_q", q, 0);
    check("mrst_q_valid", q_valid, 0);
    check("mrst_slip_off", slip_off, 0);
    check("mrst_load", load, 0);
    rst = 1'b0;
    tick();
    check("mrel_load", load, 1);
    check("mrel_q_valid", q_valid, 0);
    do_word(4'hD, 4'hF, 4'hF, 4'b0000, 4'h0, 4'h0, 2'd0, -1);
    do_word(4'h2, 4'hF, 4'hF, 4'b0000, 4'hD, 4'hF, 2'd0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
